// File: rtl/fetch_ctrl_pkg.sv
// Fetch controller shared types and defaults.
// FSM encoding is visible on the debug state port.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } fc_state_t;

  localparam int BOOT_HOLD_DEF = 2;
  localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller signal bundle.
// slave = controller side, master = pipeline/testbench side.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             hazard_stall;
  logic             imem_ready;
  logic             ex_br_taken;
  logic [31:0]      ex_br_target;
  logic             trap_req;
  logic [31:0]      trap_target;
  logic             halt_req;
  logic             imem_req;
  logic             pc_stall;
  logic             ex_redirect_taken;
  logic [31:0]      ex_branch_target;
  logic             flush_ifid;
  logic             flush_idex;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  modport slave (
    input  hazard_stall, imem_ready,
    input  ex_br_taken, ex_br_target,
    input  trap_req, trap_target, halt_req,
    output imem_req, pc_stall,
    output ex_redirect_taken, ex_branch_target,
    output flush_ifid, flush_idex,
    output redirect_cnt, stall_cnt, state
  );

  modport master (
    output hazard_stall, imem_ready,
    output ex_br_taken, ex_br_target,
    output trap_req, trap_target, halt_req,
    input  imem_req, pc_stall,
    input  ex_redirect_taken, ex_branch_target,
    input  flush_ifid, flush_idex,
    input  redirect_cnt, stall_cnt, state
  );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: boot hold, imem wait, redirect
// arbitration (halt > trap > branch) and stats.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_HOLD = BOOT_HOLD_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic        clk,
  input logic        rst,
  fetch_ctrl_if.slave bus
);
  fc_state_t   state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_trap_q, pend_trap_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        take_trap, take_br, accept;
  logic        sel_vld, sel_trap;
  logic [31:0] sel_tgt;
  logic        redir_inc, stall_inc;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_trap_d = pend_trap_q;
    pend_tgt_d  = pend_tgt_q;
    take_trap = 1'b0;
    take_br   = 1'b0;
    accept    = 1'b0;
    sel_vld   = 1'b0;
    sel_trap  = 1'b0;
    sel_tgt   = '0;
    redir_inc = 1'b0;
    stall_inc = 1'b0;
    bus.imem_req          = 1'b0;
    bus.pc_stall          = 1'b1;
    bus.ex_redirect_taken = 1'b0;
    bus.ex_branch_target  = '0;
    bus.flush_ifid        = 1'b0;
    bus.flush_idex        = 1'b0;

    if (!rst) begin
      unique case (state_q)
        S_BOOT: begin
          if (boot_cnt_q == 4'(BOOT_HOLD - 1))
            state_d = S_RUN;
          else
            boot_cnt_d = boot_cnt_q + 4'd1;
        end
        S_RUN, S_WAIT: begin
          bus.imem_req = 1'b1;
          bus.pc_stall = bus.hazard_stall
                       | ~bus.imem_ready;
          stall_inc = bus.pc_stall;
          if (bus.halt_req) begin
            pend_vld_d = 1'b0;
            state_d    = S_HALT;
          end else begin
            // a pending trap is never replaced
            take_trap = bus.trap_req
                      & ~(pend_vld_q & pend_trap_q);
            take_br = bus.ex_br_taken
                    & ~bus.trap_req & ~pend_vld_q;
            accept  = take_trap | take_br;
            sel_vld = pend_vld_q | accept;
            unique case (1'b1)
              take_trap: begin
                sel_trap = 1'b1;
                sel_tgt  = bus.trap_target;
              end
              take_br: begin
                sel_trap = 1'b0;
                sel_tgt  = bus.ex_br_target;
              end
              default: begin
                sel_trap = pend_trap_q;
                sel_tgt  = pend_tgt_q;
              end
            endcase
            if (bus.imem_ready && sel_vld) begin
              bus.ex_redirect_taken = 1'b1;
              bus.ex_branch_target  = sel_tgt;
              redir_inc  = 1'b1;
              pend_vld_d = 1'b0;
            end else begin
              pend_vld_d  = sel_vld;
              pend_trap_d = sel_trap;
              pend_tgt_d  = sel_tgt;
            end
            bus.flush_ifid = accept;
            bus.flush_idex = accept
              | (bus.hazard_stall
                 & ~bus.ex_redirect_taken
                 & ((state_q == S_RUN)
                    | bus.imem_ready));
            state_d = bus.imem_ready ? S_RUN : S_WAIT;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_trap_q <= pend_trap_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk (clk),
    .clr (rst),
    .inc (redir_inc),
    .cnt (bus.redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_inc),
    .cnt (bus.stall_cnt)
  );

  assign bus.state = state_q;
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter BOOT_HOLD, default 2: cycles after reset with fetch held off (1..15).
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port hazard_stall  in  1  load-use hazard from ID.
REQ-006 SHALL have port imem_ready  in  1  instruction memory completes the current fetch this cycle.
REQ-007 SHALL have port ex_br_taken  in  1  EX-stage branch/jump mispredict.
REQ-008 SHALL have port ex_br_target  in  32  EX redirect target.
REQ-009 SHALL have port trap_req  in  1  trap from WB.
REQ-010 SHALL have port trap_target  in  32  trap vector.
REQ-011 SHALL have port halt_req  in  1  ebreak/ecall halt from WB.
REQ-012 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-013 SHALL have port pc_stall  out  1  hold PC (to PC register).
REQ-014 SHALL have port ex_redirect_taken  out  1  load redirect target into PC this cycle.
REQ-015 SHALL have port ex_branch_target  out  32  redirect target to PC register.
REQ-016 SHALL have port flush_ifid  out  1  and flush_idex  out  1  pipeline-register bubble insertion.
REQ-017 SHALL have ports redirect_cnt and stall_cnt, both  out  CNT_W  saturating statistics.
REQ-018 SHALL have port state  out  2  current FSM state, for debug.

Function
REQ-019 SHALL implement states BOOT(0), RUN(1), WAIT(2), HALT(3).
REQ-020 BOOT: pc_stall=1, imem_req=0; after exactly BOOT_HOLD cycles -> RUN.
REQ-021 RUN: imem_req=1; imem_ready=0 -> WAIT; pc_stall = hazard_stall | ~imem_ready.
REQ-022 WAIT: imem_req=1, pc_stall=1 except in the imem_ready cycle, which behaves as RUN; imem_ready=1 -> RUN.
REQ-023 Event priority, in RUN and WAIT, SHALL be halt_req > trap_req > ex_br_taken.
REQ-024 halt_req SHALL enter HALT next cycle, drop any pending redirect and emit no redirect.
REQ-025 HALT SHALL hold pc_stall=1, imem_req=0, no redirect; only rst exits.
REQ-026 Redirect with imem_ready=1: ex_redirect_taken=1 and ex_branch_target=selected target in the same cycle (combinational, zero latency).
REQ-027 Redirect with imem_ready=0: capture target into a pending register; issue it in the first cycle imem_ready=1.
REQ-028 While a redirect is pending: ex_br_taken SHALL be ignored; trap_req SHALL overwrite a pending branch; a pending trap SHALL NOT be overwritten.
REQ-029 flush_ifid=flush_idex=1 in the cycle a redirect is accepted (immediate or captured), not again at issue.
REQ-030 flush_idex=1 also when hazard_stall=1 in RUN with no redirect.
REQ-031 ex_branch_target SHALL be 0 whenever ex_redirect_taken=0.
REQ-032 redirect_cnt SHALL +1 per issued redirect; stall_cnt SHALL +1 per RUN/WAIT cycle with pc_stall=1.
REQ-033 Both counters SHALL saturate at all-ones, never wrap.

Reset
REQ-034 rst SHALL set state=BOOT, boot counter=0, pending cleared, counters=0.
REQ-035 Reset values SHALL be: pc_stall=1, imem_req=0, ex_redirect_taken=0, ex_branch_target=0, flushes=0.
REQ-036 rst asserted mid-operation (WAIT with a pending redirect, or HALT) SHALL discard all state next edge, with no redirect issued.

Structure
REQ-037 Package fetch_ctrl_pkg SHALL hold the state encoding and the default BOOT_HOLD/CNT_W constants.
REQ-038 Sub-module sat_counter (width parameter, inc, synchronous clear) SHALL be instantiated twice.

Verification
REQ-039 rst 1 cycle then idle, BOOT_HOLD=2 -> pc_stall=1 for 2 cycles, state RUN on the 3rd, imem_req=1.
REQ-040 RUN, imem_ready=1, ex_br_taken=1, target 0x40 -> same-cycle ex_redirect_taken=1, target 0x40, both flushes, redirect_cnt=1.
REQ-041 imem_ready=0 for 3 cycles, branch 0x80 in cycle 1, trap 0x100 in cycle 2 -> flushes in cycles 1 and 2; redirect 0x100 issued once on the imem_ready cycle.
REQ-042 halt_req and trap_req in the same cycle -> HALT, no redirect, pc_stall=1 until rst.
REQ-043 Hold pc_stall>65535 cycles (CNT_W=16) -> stall_cnt stays 0xFFFF.
